vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 257 +++++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA timing receiver with pixel coordinates and lock detection
//
// Purpose: registers incoming VGA sync/blank/RGB once, measures line length
// (h_total) and frame height (v_total), produces pixel coordinates, and runs a
// lock FSM that declares the timing stable after one clean frame.
//
// Ports:
//   vga_clock    - sole clock, rising edge
//   resetn       - asynchronous active-low reset
//   hs_n, vs_n   - horizontal / vertical sync, active low
//   blank        - high while the pixel is visible
//   rgb_in       - {R,G,B} 8 bits each
//   x, y         - coordinates of the current visible pixel
//   pixel_valid  - x/y/pixel_colour valid
//   pixel_colour - {R[7],G[7],B[7]}
//   line_start   - pulse with the first pixel of each line
//   frame_start  - pulse with pixel (0,0)
//   h_total      - measured cycles per line
//   v_total      - measured lines per frame
//   locked       - timing stable
//   sync_error   - one-cycle pulse when lock is lost
module vga_sync_receiver #(
   parameter logic [9:0] H_TIMEOUT = 10'd1023,
   parameter logic [9:0] V_TIMEOUT = 10'd1023
) (
   input  logic        vga_clock,
   input  logic        resetn,
   input  logic        hs_n,
   input  logic        vs_n,
   input  logic        blank,
   input  logic [23:0] rgb_in,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        pixel_valid,
   output logic [2:0]  pixel_colour,
   output logic        line_start,
   output logic        frame_start,
   output logic [9:0]  h_total,
   output logic [9:0]  v_total,
   output logic        locked,
   output logic        sync_error
);

   localparam logic [9:0] CNT_MAX = 10'h3FF;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   // stage 1 and its delayed copy used for edge detection
   logic        hs1_q, vs1_q, blank1_q;
   logic [23:0] rgb1_q;
   logic        hs2_q, vs2_q, blank2_q;

   // measurement counters
   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  lcnt_q, lcnt_d;
   logic        h_seen_q, h_seen_d;
   logic        v_seen_q, v_seen_d;
   logic [9:0]  h_total_q, h_total_d;
   logic [9:0]  v_total_q, v_total_d;

   // stage 2 pixel outputs
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        pv_q, pv_d;
   logic [2:0]  colour_q, colour_d;
   logic        ls_q, ls_d;
   logic        fs_q, fs_d;

   // lock FSM
   state_t      state_q, state_d;
   logic [9:0]  ref_q, ref_d;
   logic        mism_q, mism_d;
   logic        locked_q, locked_d;
   logic        sync_error_q, sync_error_d;

   logic        hs_fall, vs_fall, blank_rise, blank_fall;
   logic [9:0]  period;
   logic        period_ok;
   logic [9:0]  h_cur;
   logic        timeout;
   logic        unused_rgb;

   assign hs_fall    = hs2_q & ~hs1_q;
   assign vs_fall    = vs2_q & ~vs1_q;
   assign blank_rise = blank1_q & ~blank2_q;
   assign blank_fall = blank2_q & ~blank1_q;

   // Length of the line that ends at this HS fall. The first fall after reset
   // has no preceding fall, so its count is not a real period.
   assign period    = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
   assign period_ok = hs_fall & h_seen_q;
   assign h_cur     = period_ok ? period : h_total_q;
   assign timeout   = (hcnt_q >= H_TIMEOUT) | (lcnt_q >= V_TIMEOUT);

   // only the colour MSBs are used downstream
   assign unused_rgb = ^{rgb1_q[22:16], rgb1_q[14:8], rgb1_q[6:0]};

   always_comb begin
      hcnt_d    = hs_fall ? 10'd0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1);
      h_seen_d  = h_seen_q | hs_fall;
      h_total_d = period_ok ? period : h_total_q;

      // an HS fall coincident with VS fall is the first line of the new frame
      lcnt_d = lcnt_q;
      if (vs_fall) begin
         lcnt_d = hs_fall ? 10'd1 : 10'd0;
      end else if (hs_fall && lcnt_q != CNT_MAX) begin
         lcnt_d = lcnt_q + 10'd1;
      end
      v_seen_d  = v_seen_q | vs_fall;
      v_total_d = (vs_fall && v_seen_q) ? lcnt_q : v_total_q;
   end

   always_comb begin
      x_d = x_q;
      if (blank_rise) begin
         x_d = 10'd0;
      end else if (blank1_q && x_q != CNT_MAX) begin
         x_d = x_q + 10'd1;
      end

      // row advances after each visible line; VS fall wins over a coincident blank fall
      y_d = y_q;
      if (vs_fall) begin
         y_d = 10'd0;
      end else if (blank_fall && y_q != CNT_MAX) begin
         y_d = y_q + 10'd1;
      end

      pv_d     = blank1_q;
      colour_d = blank1_q ? {rgb1_q[23], rgb1_q[15], rgb1_q[7]} : 3'b000;
      ls_d     = blank_rise;
      fs_d     = blank_rise & (y_d == 10'd0);
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      mism_d  = mism_q;
      case (state_q)
         ST_UNLOCKED: begin
            if (vs_fall) begin
               state_d = ST_ACQUIRE;
               ref_d   = h_cur;
               mism_d  = 1'b0;
            end
         end
         ST_ACQUIRE: begin
            // the line ending on the VS-fall cycle still belongs to the frame being judged
            if (vs_fall) begin
               if (!mism_q && !(period_ok && period != ref_q)) begin
                  state_d = ST_LOCKED;
               end else begin
                  ref_d  = h_cur;
                  mism_d = 1'b0;
               end
            end else if (period_ok && period != ref_q) begin
               mism_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if ((period_ok && period != h_total_q) ||
                (vs_fall && v_seen_q && lcnt_q != v_total_q)) begin
               state_d = ST_UNLOCKED;
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase
      if (timeout) begin
         state_d = ST_UNLOCKED;
      end
   end

   // FSM: outputs
   always_comb begin
      locked_d     = (state_d == ST_LOCKED);
      sync_error_d = (state_q != ST_UNLOCKED) && (state_d == ST_UNLOCKED);
   end

   // FSM: state register
   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_UNLOCKED;
         ref_q        <= 10'd0;
         mism_q       <= 1'b0;
         locked_q     <= 1'b0;
         sync_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         mism_q       <= mism_d;
         locked_q     <= locked_d;
         sync_error_q <= sync_error_d;
      end
   end

   always_ff @(posedge vga_clock or negedge resetn) begin
      if (!resetn) begin
         hs1_q     <= 1'b0;
         vs1_q     <= 1'b0;
         blank1_q  <= 1'b0;
         rgb1_q    <= 24'd0;
         hs2_q     <= 1'b0;
         vs2_q     <= 1'b0;
         blank2_q  <= 1'b0;
         hcnt_q    <= 10'd0;
         lcnt_q    <= 10'd0;
         h_seen_q  <= 1'b0;
         v_seen_q  <= 1'b0;
         h_total_q <= 10'd0;
         v_total_q <= 10'd0;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         pv_q      <= 1'b0;
         colour_q  <= 3'b000;
         ls_q      <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         hs1_q     <= hs_n;
         vs1_q     <= vs_n;
         blank1_q  <= blank;
         rgb1_q    <= rgb_in;
         hs2_q     <= hs1_q;
         vs2_q     <= vs1_q;
         blank2_q  <= blank1_q;
         hcnt_q    <= hcnt_d;
         lcnt_q    <= lcnt_d;
         h_seen_q  <= h_seen_d;
         v_seen_q  <= v_seen_d;
         h_total_q <= h_total_d;
         v_total_q <= v_total_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pv_q      <= pv_d;
         colour_q  <= colour_d;
         ls_q      <= ls_d;
         fs_q      <= fs_d;
      end
   end

   assign x            = x_q;
   assign y            = y_q;
   assign pixel_valid  = pv_q;
   assign pixel_colour = colour_q;
   assign line_start   = ls_q;
   assign frame_start  = fs_q;
   assign h_total      = h_total_q;
   assign v_total      = v_total_q;
   assign locked       = locked_q;
   assign sync_error   = sync_error_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - scoreboard bench for vga_sync_receiver on a scaled 40x20 raster
module tb_vga_sync_receiver;

   // scaled raster: 40 cycles/line, 16 visible, HS low 24..27; 20 lines, 8 visible, VS low lines 12..13
   localparam int HT  = 40;
   localparam int HV  = 16;
   localparam int HS0 = 24;
   localparam int HS1 = 27;
   localparam int VT  = 20;
   localparam int VV  = 8;

   logic        clk;
   logic        resetn;
   logic        hs_n, vs_n, blank;
   logic [23:0] rgb_in;
   logic [9:0]  x, y, h_total, v_total;
   logic        pixel_valid, line_start, frame_start, locked, sync_error;
   logic [2:0]  pixel_colour;

   typedef struct {
      int         cyc;
      logic [9:0] px;
      logic [9:0] py;
      logic [2:0] col;
      logic       ls;
      logic       fs;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   err_cnt = 0;
   int   err_cyc = 0;
   int   hs_fall_cyc = 0;

   vga_sync_receiver dut (
      .vga_clock   (clk),
      .resetn      (resetn),
      .hs_n        (hs_n),
      .vs_n        (vs_n),
      .blank       (blank),
      .rgb_in      (rgb_in),
      .x           (x),
      .y           (y),
      .pixel_valid (pixel_valid),
      .pixel_colour(pixel_colour),
      .line_start  (line_start),
      .frame_start (frame_start),
      .h_total     (h_total),
      .v_total     (v_total),
      .locked      (locked),
      .sync_error  (sync_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a pixel
   initial forever begin
      @(negedge clk);
      if (resetn) begin
         if (sync_error) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (pixel_valid) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL pixel_unexpected: cyc %0d x=%0d y=%0d", cyc, x, y);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.cyc != cyc || e.px !== x || e.py !== y || e.col !== pixel_colour ||
                   e.ls !== line_start || e.fs !== frame_start) begin
                  n_fail++;
                  $display("FAIL pixel: got cyc=%0d x=%0d y=%0d col=%b ls=%b fs=%b expected cyc=%0d x=%0d y=%0d col=%b ls=%b fs=%b",
                           cyc, x, y, pixel_colour, line_start, frame_start,
                           e.cyc, e.px, e.py, e.col, e.ls, e.fs);
               end
            end
         end else if (line_start || frame_start) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_without_valid: ls=%b fs=%b expected 0 0", line_start, frame_start);
         end
      end
   end

   task automatic drive(input logic h, input logic v, input logic b,
                        input int xc, input int yc, input logic [23:0] rgb);
      exp_t e;
      @(posedge clk);
      #1;
      hs_n   = h;
      vs_n   = v;
      blank  = b;
      rgb_in = rgb;
      if (b) begin
         e.cyc = cyc + 2;
         e.px  = xc[9:0];
         e.py  = yc[9:0];
         e.col = (rgb == 24'hFF00FF) ? 3'b101 : {rgb[23], rgb[15], rgb[7]};
         e.ls  = (xc == 0);
         e.fs  = (xc == 0) && (yc == 0);
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 0, 0, 24'd0);
   endtask

   task automatic drive_frame(input int short_line, input bit coinc,
                              input int start_line, input int abort_line, input int abort_cyc);
      for (int l = start_line; l < VT; l++) begin
         int len;
         len = (l == short_line) ? HT - 1 : HT;
         for (int c = 0; c < len; c++) begin
            logic h, v, b;
            logic [23:0] rgb;
            if (l == abort_line && c == abort_cyc) return;
            h = !(c >= HS0 && c <= HS1);
            if (coinc) v = !((l == 12 && c >= HS0) || l == 13 || (l == 14 && c < HS0));
            else       v = !(l == 12 || l == 13);
            b = (c < HV) && (l < VV);
            rgb = (l == 0 && c == 0) ? 24'hFF00FF : 24'($urandom());
            drive(h, v, b, c, l, rgb);
            if (c == HS0) hs_fall_cyc = cyc;
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      hs_n   = 1'b1;
      vs_n   = 1'b1;
      blank  = 1'b0;
      rgb_in = 24'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pixel", 32'({x, y, pixel_valid, pixel_colour, line_start, frame_start}), 0);
      chk("rst_totals", 32'({h_total, v_total}), 0);
      chk("rst_lock", 32'({locked, sync_error}), 0);
      resetn = 1'b1;
      idle(4);

      drive_frame(-1, 0, 0, -1, -1);
      chk("f1_locked", 32'(locked), 0);
      chk("f1_h_total", 32'(h_total), HT);
      drive_frame(-1, 0, 0, -1, -1);
      chk("f2_locked", 32'(locked), 1);
      chk("f2_v_total", 32'(v_total), VT);
      drive_frame(-1, 0, 0, -1, -1);
      chk("f3_locked", 32'(locked), 1);
      chk("f3_errors", 32'(err_cnt), 0);

      drive_frame(5, 0, 0, -1, -1);
      chk("short_locked", 32'(locked), 0);
      chk("short_errors", 32'(err_cnt), 1);
      drive_frame(-1, 0, 0, -1, -1);
      chk("relock_locked", 32'(locked), 1);
      chk("relock_h_total", 32'(h_total), HT);

      idle(1100);
      chk("timeout_errors", 32'(err_cnt), 2);
      chk("timeout_locked", 32'(locked), 0);
      chk("timeout_cycle", 32'(err_cyc), 32'(hs_fall_cyc + 1026));

      drive_frame(-1, 1, 0, -1, -1);
      chk("coinc1_v_total", 32'(v_total), VT);
      drive_frame(-1, 1, 0, -1, -1);
      chk("coinc2_v_total", 32'(v_total), VT);
      chk("coinc2_locked", 32'(locked), 1);

      drive_frame(-1, 0, 0, 3, 5);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      hs_n   = 1'b1;
      vs_n   = 1'b1;
      blank  = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_pixel", 32'({x, y, pixel_valid, pixel_colour, line_start, frame_start}), 0);
      chk("async_rst_state", 32'({locked, sync_error, h_total, v_total}), 0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(3);

      drive_frame(-1, 0, 0, 1, 0);
      chk("post_rst_h_total_first", 32'(h_total), 0);
      drive_frame(-1, 0, 1, -1, -1);
      chk("post_rst_locked1", 32'(locked), 0);
      chk("post_rst_v_total1", 32'(v_total), 0);
      chk("post_rst_h_total", 32'(h_total), HT);
      drive_frame(-1, 0, 0, -1, -1);
      chk("post_rst_locked2", 32'(locked), 1);
      chk("post_rst_v_total2", 32'(v_total), VT);
      chk("final_errors", 32'(err_cnt), 2);

      idle(5);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
